// File: rtl/dma_controller_pkg.sv
// Shared constants and types for the single-channel memory-to-memory DMA engine.
// Contents: memory-map window, register offsets, CTRL/STATUS bit positions, FSM state enum.
// Imported by the register block and the engine top.
package dma_controller_pkg;

  localparam int XLEN              = 64;
  localparam int MEMBUS_DATA_WIDTH = 64;

  localparam logic [63:0] MMAP_DMA_BEGIN = 64'h0000_0000_0300_0000;
  localparam logic [63:0] MMAP_DMA_END   = 64'h0000_0000_0300_0FFF;

  // Register offsets relative to MMAP_DMA_BEGIN
  localparam logic [11:0] DMA_OFF_CTRL   = 12'h000;
  localparam logic [11:0] DMA_OFF_SRC    = 12'h004;
  localparam logic [11:0] DMA_OFF_DST    = 12'h008;
  localparam logic [11:0] DMA_OFF_LEN    = 12'h00C;
  localparam logic [11:0] DMA_OFF_STATUS = 12'h010;

  // CTRL bits
  localparam int DMA_CTRL_START = 0;
  localparam int DMA_CTRL_CLR   = 1;
  localparam int DMA_CTRL_IRQEN = 2;

  // STATUS bits
  localparam int DMA_ST_BUSY = 0;
  localparam int DMA_ST_DONE = 1;
  localparam int DMA_ST_ERR  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } DmaState;

endpackage

// File: rtl/dma_controller_if.sv
// Bus interfaces of the DMA engine: MMIO register port and membus master port.
// dma_mmio_if: s_valid/s_addr/s_wen/s_wdata in, s_ready/s_rvalid/s_rdata out (slave view).
// dma_membus_if: m_valid/m_addr/m_wen/m_wdata/m_wmask out, m_ready/m_rvalid/m_rdata in (master view).
interface dma_mmio_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                  s_valid;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic                  s_wen;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_rvalid;
  logic [DATA_WIDTH-1:0] s_rdata;

  modport slave  (input  s_valid, s_addr, s_wen, s_wdata,
                  output s_ready, s_rvalid, s_rdata);
  modport master (output s_valid, s_addr, s_wen, s_wdata,
                  input  s_ready, s_rvalid, s_rdata);
endinterface

interface dma_membus_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                    m_valid;
  logic                    m_ready;
  logic [ADDR_WIDTH-1:0]   m_addr;
  logic                    m_wen;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wmask;
  logic                    m_rvalid;
  logic [DATA_WIDTH-1:0]   m_rdata;

  modport master (output m_valid, m_addr, m_wen, m_wdata, m_wmask,
                  input  m_ready, m_rvalid, m_rdata);
  modport slave  (input  m_valid, m_addr, m_wen, m_wdata, m_wmask,
                  output m_ready, m_rvalid, m_rdata);
endinterface

// File: rtl/dma_controller_regs.sv
// DMA register file: MMIO decode, SRC/DST/LEN/irq_en storage, start/clear pulses, read mux.
// Latency: writes take effect on the next edge; read data returns one cycle after the request.
// Backpressure: none, s_ready is tied high. Ports: clk/rst, mmio slave, engine status in, config out.
module dma_regs
  import dma_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  dma_mmio_if.slave   mmio,
  input  logic        i_busy,
  input  logic        i_done,
  input  logic        i_err,
  output logic        o_start,
  output logic        o_clr,
  output logic        o_irq_en,
  output logic [31:0] o_src,
  output logic [31:0] o_dst,
  output logic [31:0] o_len
);

  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_wr;
  logic                  w_rd;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rmux;
  logic [31:0]           w_status;
  logic                  w_unused;

  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [31:0] r_len;
  logic        r_irq_en;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  assign w_off    = mmio.s_addr - ADDR_WIDTH'(MMAP_DMA_BEGIN);
  assign w_wr     = mmio.s_valid & mmio.s_wen;
  assign w_rd     = mmio.s_valid & ~mmio.s_wen;
  assign w_wdata  = mmio.s_wdata[31:0];
  assign w_unused = &{1'b0, mmio.s_wdata[DATA_WIDTH-1:32]};

  // start/clear are single-cycle pulses; start is dropped while a transfer runs
  assign o_start = w_wr & (w_off == ADDR_WIDTH'(DMA_OFF_CTRL)) & w_wdata[DMA_CTRL_START] & ~i_busy;
  assign o_clr   = w_wr & (w_off == ADDR_WIDTH'(DMA_OFF_CTRL)) & w_wdata[DMA_CTRL_CLR];

  always_comb begin
    w_status              = '0;
    w_status[DMA_ST_BUSY] = i_busy;
    w_status[DMA_ST_DONE] = i_done;
    w_status[DMA_ST_ERR]  = i_err;
  end

  always_comb begin
    w_rmux = '0;
    if (w_off == ADDR_WIDTH'(DMA_OFF_CTRL))        w_rmux[DMA_CTRL_IRQEN] = r_irq_en;
    else if (w_off == ADDR_WIDTH'(DMA_OFF_SRC))    w_rmux = r_src;
    else if (w_off == ADDR_WIDTH'(DMA_OFF_DST))    w_rmux = r_dst;
    else if (w_off == ADDR_WIDTH'(DMA_OFF_LEN))    w_rmux = r_len;
    else if (w_off == ADDR_WIDTH'(DMA_OFF_STATUS)) w_rmux = w_status;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_irq_en <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rmux;
      if (w_wr) begin
        if (w_off == ADDR_WIDTH'(DMA_OFF_CTRL)) r_irq_en <= w_wdata[DMA_CTRL_IRQEN];
        // transfer parameters are frozen while the engine is busy
        if (!i_busy) begin
          if (w_off == ADDR_WIDTH'(DMA_OFF_SRC)) r_src <= w_wdata;
          if (w_off == ADDR_WIDTH'(DMA_OFF_DST)) r_dst <= w_wdata;
          if (w_off == ADDR_WIDTH'(DMA_OFF_LEN)) r_len <= w_wdata;
        end
      end
    end
  end

  assign mmio.s_ready  = 1'b1;
  assign mmio.s_rvalid = r_rvalid;
  assign mmio.s_rdata  = {{(DATA_WIDTH-32){1'b0}}, r_rdata};
  assign o_src         = r_src;
  assign o_dst         = r_dst;
  assign o_len         = r_len;
  assign o_irq_en      = r_irq_en;

endmodule

// File: rtl/dma_controller.sv
// Single-channel memory-to-memory DMA: copies LEN bytes one beat at a time (read then write).
// Latency: per beat one read handshake, read response, one write handshake; done/irq on the last write.
// Backpressure: holds m_valid/m_addr/m_wen/m_wdata until m_ready. Ports: clk/rst, mmio slave, membus master, irq.
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int DATA_WIDTH = MEMBUS_DATA_WIDTH,
  parameter int ADDR_WIDTH = XLEN
) (
  input  logic        clk,
  input  logic        rst,
  dma_mmio_if.slave   mmio,
  dma_membus_if.master mem,
  output logic        irq
);

  localparam logic [31:0] BEAT_BYTES = 32'(DATA_WIDTH / 8);
  localparam logic [31:0] BEAT_MASK  = BEAT_BYTES - 32'd1;

  logic        w_start;
  logic        w_clr;
  logic        w_irq_en;
  logic [31:0] w_src;
  logic [31:0] w_dst;
  logic [31:0] w_len;
  logic        w_misaligned;

  DmaState               r_state;
  logic                  r_m_valid;
  logic                  r_m_wen;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [31:0]           r_cur_src;
  logic [31:0]           r_cur_dst;
  logic [31:0]           r_remain;
  logic                  r_done;
  logic                  r_err;

  dma_regs #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_regs (
    .clk      (clk),
    .rst      (rst),
    .mmio     (mmio),
    .i_busy   (r_state != IDLE),
    .i_done   (r_done),
    .i_err    (r_err),
    .o_start  (w_start),
    .o_clr    (w_clr),
    .o_irq_en (w_irq_en),
    .o_src    (w_src),
    .o_dst    (w_dst),
    .o_len    (w_len)
  );

  assign w_misaligned = |(w_src & BEAT_MASK) | |(w_dst & BEAT_MASK) | |(w_len & BEAT_MASK);

  // Later assignments in this block override the clear_done pulse, so a clear and a
  // start/completion in the same cycle resolve as "clear first, then set".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_m_valid <= 1'b0;
      r_m_wen   <= 1'b0;
      r_m_addr  <= '0;
      r_buf     <= '0;
      r_cur_src <= '0;
      r_cur_dst <= '0;
      r_remain  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_clr) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            if (w_misaligned) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else if (w_len == '0) begin
              r_err  <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_err     <= 1'b0;
              r_cur_src <= w_src;
              r_cur_dst <= w_dst;
              r_remain  <= w_len;
              r_m_valid <= 1'b1;
              r_m_wen   <= 1'b0;
              r_m_addr  <= ADDR_WIDTH'(w_src);
              r_state   <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (mem.m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem.m_rvalid) begin
            r_buf     <= mem.m_rdata;
            r_m_valid <= 1'b1;
            r_m_wen   <= 1'b1;
            r_m_addr  <= ADDR_WIDTH'(r_cur_dst);
            r_state   <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (mem.m_ready) begin
            r_cur_src <= r_cur_src + BEAT_BYTES;
            r_cur_dst <= r_cur_dst + BEAT_BYTES;
            r_remain  <= r_remain - BEAT_BYTES;
            r_m_wen   <= 1'b0;
            // remain is about to drop by one beat; this was the last beat if it equals one beat now
            if (r_remain == BEAT_BYTES) begin
              r_done    <= 1'b1;
              r_m_valid <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_m_addr  <= ADDR_WIDTH'(r_cur_src + BEAT_BYTES);
              r_state   <= RD_REQ;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem.m_valid = r_m_valid;
  assign mem.m_wen   = r_m_wen;
  assign mem.m_addr  = r_m_addr;
  assign mem.m_wdata = r_buf;
  assign mem.m_wmask = '1;
  assign irq         = w_irq_en & r_done;

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller with a membus slave model and transaction scoreboard.
module tb_dma_controller;
  import dma_controller_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic irq;

  dma_mmio_if   mmio_bus ();
  dma_membus_if mem_bus ();

  dma_controller #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk  (clk),
    .rst  (rst),
    .mmio (mmio_bus),
    .mem  (mem_bus),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
  } xact_t;

  xact_t       exp_q[$];
  logic [31:0] rd_q[$];
  logic [63:0] mem_m [logic [31:0]];
  int n_tests = 0;
  int n_fail = 0;
  int stall_cycles = 0;
  int rsp_delay = 1;
  int rd_hs_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Membus slave: decides m_ready on negedges, answers reads after rsp_delay negedges,
  // checks every handshake against the expected-transaction queue.
  initial begin : slave_model
    int          wait_cnt;
    int          rsp_cnt;
    logic [31:0] rsp_addr;
    logic [63:0] held_addr;
    logic        held_wen;
    xact_t       e;
    wait_cnt = 0; rsp_cnt = 0; rsp_addr = '0; held_addr = '0; held_wen = 1'b0;
    mem_bus.m_ready = 1'b0; mem_bus.m_rvalid = 1'b0; mem_bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      mem_bus.m_rvalid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_bus.m_rvalid = 1'b1;
          mem_bus.m_rdata  = mem_m[rsp_addr];
        end
      end
      mem_bus.m_ready = 1'b0;
      if (wait_cnt > 0) begin
        check("stall_valid", 64'(mem_bus.m_valid), 64'd1);
        check("stall_addr", mem_bus.m_addr, held_addr);
        check("stall_wen", 64'(mem_bus.m_wen), 64'(held_wen));
      end
      if (mem_bus.m_valid === 1'b1) begin
        if (wait_cnt < stall_cycles) begin
          if (wait_cnt == 0) begin
            held_addr = mem_bus.m_addr;
            held_wen  = mem_bus.m_wen;
          end
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          mem_bus.m_ready = 1'b1;
          check("wmask", 64'(mem_bus.m_wmask), 64'hFF);
          check("req_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("req_addr", mem_bus.m_addr, e.addr);
            check("req_wen", 64'(mem_bus.m_wen), 64'(e.wen));
            if (e.wen) check("req_wdata", mem_bus.m_wdata, e.wdata);
          end
          if (mem_bus.m_wen) begin
            mem_m[mem_bus.m_addr[31:0]] = mem_bus.m_wdata;
          end else begin
            rsp_cnt  = rsp_delay;
            rsp_addr = mem_bus.m_addr[31:0];
            rd_hs_count++;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // MMIO helpers: called just after a negedge, return just after the next negedge.
  task automatic mmio_wr(input logic [11:0] off, input logic [31:0] val);
    mmio_bus.s_valid = 1'b1;
    mmio_bus.s_wen   = 1'b1;
    mmio_bus.s_addr  = MMAP_DMA_BEGIN + 64'(off);
    mmio_bus.s_wdata = {32'hDEAD_BEEF, val};
    @(negedge clk);
    mmio_bus.s_valid = 1'b0;
    mmio_bus.s_wen   = 1'b0;
  endtask

  task automatic mmio_rd(input logic [11:0] off, output logic [63:0] data, output logic vld);
    mmio_bus.s_valid = 1'b1;
    mmio_bus.s_wen   = 1'b0;
    mmio_bus.s_addr  = MMAP_DMA_BEGIN + 64'(off);
    @(negedge clk);
    mmio_bus.s_valid = 1'b0;
    data = mmio_bus.s_rdata;
    vld  = mmio_bus.s_rvalid;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] off, input logic [31:0] exp);
    logic [63:0] d;
    logic        v;
    rd_q.push_back(exp);
    mmio_rd(off, d, v);
    check({tag, "_rvalid"}, 64'(v), 64'd1);
    if (v) check(tag, d, 64'(rd_q.pop_front()));
    else rd_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [63:0] d;
    logic        v;
    d = 64'd1;
    for (int i = 0; i < budget; i++) begin
      mmio_rd(DMA_OFF_STATUS, d, v);
      if (d[DMA_ST_BUSY] == 1'b0) break;
    end
    check({tag, "_idle"}, 64'(d[DMA_ST_BUSY]), 64'd0);
  endtask

  // Loads source memory with random beats and queues the read/write pairs the engine must issue.
  task automatic prep(input logic [31:0] src, input logic [31:0] dst, input int beats);
    logic [63:0] d;
    logic [31:0] sa;
    logic [31:0] da;
    for (int i = 0; i < beats; i++) begin
      d  = {$urandom, $urandom};
      sa = src + 32'(8 * i);
      da = dst + 32'(8 * i);
      mem_m[sa] = d;
      exp_q.push_back('{addr: 64'(sa), wen: 1'b0, wdata: 64'd0});
      exp_q.push_back('{addr: 64'(da), wen: 1'b1, wdata: d});
    end
  endtask

  task automatic mem_cmp(input string tag, input logic [31:0] src, input logic [31:0] dst, input int beats);
    for (int i = 0; i < beats; i++)
      check(tag, mem_m[dst + 32'(8 * i)], mem_m[src + 32'(8 * i)]);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    mmio_bus.s_valid = 1'b0;
    mmio_bus.s_wen   = 1'b0;
    mmio_bus.s_addr  = '0;
    mmio_bus.s_wdata = '0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_m_valid", 64'(mem_bus.m_valid), 64'd0);
    check("rst_m_wen", 64'(mem_bus.m_wen), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_wmask", 64'(mem_bus.m_wmask), 64'hFF);
    check("rst_s_rvalid", 64'(mmio_bus.s_rvalid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("s_ready", 64'(mmio_bus.s_ready), 64'd1);
    rd_chk("rst_status", DMA_OFF_STATUS, 32'h0);
    rd_chk("rst_src", DMA_OFF_SRC, 32'h0);
    rd_chk("rst_ctrl", DMA_OFF_CTRL, 32'h0);

    // Test 1: three-beat copy with IRQ enabled
    mmio_wr(DMA_OFF_SRC, 32'h8000_0000);
    mmio_wr(DMA_OFF_DST, 32'h8000_1000);
    mmio_wr(DMA_OFF_LEN, 32'h18);
    rd_chk("t1_src_rb", DMA_OFF_SRC, 32'h8000_0000);
    rd_chk("t1_len_rb", DMA_OFF_LEN, 32'h18);
    prep(32'h8000_0000, 32'h8000_1000, 3);
    mmio_wr(DMA_OFF_CTRL, 32'h5);
    wait_idle("t1", 200);
    rd_chk("t1_status", DMA_OFF_STATUS, 32'h2);
    check("t1_irq", 64'(irq), 64'd1);
    rd_chk("t1_ctrl", DMA_OFF_CTRL, 32'h4);
    mem_cmp("t1_mem", 32'h8000_0000, 32'h8000_1000, 3);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // Unmapped offsets: read zero, writes ignored
    mmio_wr(12'h020, 32'hFFFF_FFFF);
    rd_chk("unmapped_20", 12'h020, 32'h0);
    rd_chk("unmapped_14", 12'h014, 32'h0);

    // Test 2: clear, then zero-length start
    mmio_wr(DMA_OFF_CTRL, 32'h2);
    rd_chk("t2_clr_status", DMA_OFF_STATUS, 32'h0);
    check("t2_clr_irq", 64'(irq), 64'd0);
    mmio_wr(DMA_OFF_LEN, 32'h0);
    mmio_wr(DMA_OFF_CTRL, 32'h1);
    rd_chk("t2_status", DMA_OFF_STATUS, 32'h2);
    check("t2_m_valid", 64'(mem_bus.m_valid), 64'd0);

    // Test 3: misaligned SRC with clear+start in one write -> done+err, no traffic
    mmio_wr(DMA_OFF_SRC, 32'h8000_0004);
    mmio_wr(DMA_OFF_LEN, 32'h10);
    mmio_wr(DMA_OFF_CTRL, 32'h3);
    rd_chk("t3_status", DMA_OFF_STATUS, 32'h6);
    check("t3_m_valid", 64'(mem_bus.m_valid), 64'd0);
    // next good start clears err
    mmio_wr(DMA_OFF_SRC, 32'h8000_0000);
    mmio_wr(DMA_OFF_LEN, 32'h0);
    mmio_wr(DMA_OFF_CTRL, 32'h3);
    rd_chk("t3_err_cleared", DMA_OFF_STATUS, 32'h2);

    // Test 4: slave stalls every request for 5 cycles
    mmio_wr(DMA_OFF_CTRL, 32'h2);
    stall_cycles = 5;
    mmio_wr(DMA_OFF_SRC, 32'h8000_2000);
    mmio_wr(DMA_OFF_DST, 32'h8000_3000);
    mmio_wr(DMA_OFF_LEN, 32'h10);
    prep(32'h8000_2000, 32'h8000_3000, 2);
    mmio_wr(DMA_OFF_CTRL, 32'h1);
    wait_idle("t4", 300);
    rd_chk("t4_status", DMA_OFF_STATUS, 32'h2);
    check("t4_irq_off", 64'(irq), 64'd0);
    mem_cmp("t4_mem", 32'h8000_2000, 32'h8000_3000, 2);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // Test 5: register writes and start while busy are ignored
    mmio_wr(DMA_OFF_CTRL, 32'h2);
    stall_cycles = 2;
    mmio_wr(DMA_OFF_SRC, 32'h8000_4000);
    mmio_wr(DMA_OFF_DST, 32'h8000_5000);
    mmio_wr(DMA_OFF_LEN, 32'h18);
    prep(32'h8000_4000, 32'h8000_5000, 3);
    mmio_wr(DMA_OFF_CTRL, 32'h5);
    rd_chk("t5_busy", DMA_OFF_STATUS, 32'h1);
    mmio_wr(DMA_OFF_LEN, 32'h40);
    mmio_wr(DMA_OFF_SRC, 32'h0000_1234);
    mmio_wr(DMA_OFF_CTRL, 32'h5);
    wait_idle("t5", 300);
    rd_chk("t5_status", DMA_OFF_STATUS, 32'h2);
    check("t5_irq", 64'(irq), 64'd1);
    rd_chk("t5_len_kept", DMA_OFF_LEN, 32'h18);
    rd_chk("t5_src_kept", DMA_OFF_SRC, 32'h8000_4000);
    mem_cmp("t5_mem", 32'h8000_4000, 32'h8000_5000, 3);
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);
    mmio_wr(DMA_OFF_CTRL, 32'h2);
    rd_chk("t5_clr_status", DMA_OFF_STATUS, 32'h0);
    check("t5_clr_irq", 64'(irq), 64'd0);

    // Test 6: asynchronous reset while waiting for read data
    stall_cycles = 0;
    rsp_delay    = 4;
    mmio_wr(DMA_OFF_SRC, 32'h8000_6000);
    mmio_wr(DMA_OFF_DST, 32'h8000_7000);
    mmio_wr(DMA_OFF_LEN, 32'h10);
    prep(32'h8000_6000, 32'h8000_7000, 2);
    begin
      int base;
      int waited;
      base   = rd_hs_count;
      waited = 0;
      mmio_wr(DMA_OFF_CTRL, 32'h1);
      while (rd_hs_count == base && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      check("t6_read_issued", 64'(rd_hs_count - base), 64'd1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_m_valid", 64'(mem_bus.m_valid), 64'd0);
    check("t6_rst_irq", 64'(irq), 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rsp_delay = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_post_m_valid", 64'(mem_bus.m_valid), 64'd0);
    end
    rd_chk("t6_status", DMA_OFF_STATUS, 32'h0);
    rd_chk("t6_src_reset", DMA_OFF_SRC, 32'h0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
